// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse-train generator.
package pulse_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Phase lengths of 0 are meaningless; clamp them to one cycle.
  function automatic logic [31:0] max1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable down-counter with a "reads one" flag; used for both the
// per-phase cycle count and the remaining-pulse count.
module pulse_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             last
);

  // Load has priority over decrement; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (reset)
      value <= '0;
    else if (load)
      value <= load_val;
    else if (en && (value != '0))
      value <= value - 1'b1;
  end

  assign last = (value == CNT_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse-train generator: on start, emits N pulses of W high cycles
// separated by G low cycles, then strobes done.
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] w_lat, g_lat;
  logic [CNT_W-1:0] w_in, g_in;
  logic             latch;
  logic             done_nx;

  logic             ph_load, ph_en, ph_last;
  logic [CNT_W-1:0] ph_val, ph_value;
  logic             pc_load, pc_en, pc_last;
  logic [CNT_W-1:0] pc_val;

  assign w_in = CNT_W'(max1(32'(width)));
  assign g_in = CNT_W'(max1(32'(gap)));

  // Cycles remaining in the current high or low phase.
  pulse_down_counter #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .en       (ph_en),
    .load_val (ph_val),
    .value    (ph_value),
    .last     (ph_last)
  );

  // Pulses not yet finished; its value is the pulses_left output.
  pulse_down_counter #(.CNT_W(CNT_W)) u_pulses (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .en       (pc_en),
    .load_val (pc_val),
    .value    (pulses_left),
    .last     (pc_last)
  );

  // Next-state and counter control; abort beats everything while busy.
  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    done_nx  = 1'b0;
    ph_load  = 1'b0;
    ph_en    = 1'b0;
    ph_val   = w_lat;
    pc_load  = 1'b0;
    pc_en    = 1'b0;
    pc_val   = '0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (count != '0) begin
            state_nx = HIGH;
            latch    = 1'b1;
            ph_load  = 1'b1;
            ph_val   = w_in;
            pc_load  = 1'b1;
            pc_val   = count;
          end else begin
            // Empty train: complete immediately without going busy.
            done_nx = 1'b1;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_nx = IDLE;
          ph_load  = 1'b1;
          ph_val   = '0;
          pc_load  = 1'b1;
        end else if (ph_last) begin
          pc_en = 1'b1;
          if (pc_last) begin
            // Last pulse: no trailing gap.
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = LOW;
            ph_load  = 1'b1;
            ph_val   = g_lat;
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          state_nx = IDLE;
          ph_load  = 1'b1;
          ph_val   = '0;
          pc_load  = 1'b1;
        end else if (ph_last) begin
          state_nx = HIGH;
          ph_load  = 1'b1;
          ph_val   = w_lat;
        end else begin
          ph_en = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, latched train parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      w_lat     <= '0;
      g_lat     <= '0;
      done      <= 1'b0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      done      <= done_nx;
      pulse_out <= (state_nx == HIGH);
      busy      <= (state_nx != IDLE);
      if (latch) begin
        w_lat <= w_in;
        g_lat <= g_in;
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomized + directed bench for pulse_train_gen against a waveform model.
module tb_pulse_train_gen;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [CW-1:0] width, gap, count;
  logic          pulse_out, busy, done;
  logic [CW-1:0] pulses_left;

  pulse_train_gen #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .width       (width),
    .gap         (gap),
    .count       (count),
    .abort       (abort),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .pulses_left (pulses_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          p;
    logic          b;
    logic          d;
    logic [CW-1:0] l;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;
  int   done_seen = 0;
  int   busy_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic exp_t mk(input bit p, input bit b, input bit d, input int l);
    exp_t e;
    e.p = p; e.b = b; e.d = d; e.l = CW'(l);
    return e;
  endfunction

  // Whole expected waveform of a train, one entry per cycle, ending with done.
  task automatic push_train(input int w, input int g, input int n);
    int we = (w == 0) ? 1 : w;
    int ge = (g == 0) ? 1 : g;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < we; j++) q.push_back(mk(1, 1, 0, n - i));
      if (i < n - 1)
        for (int j = 0; j < ge; j++) q.push_back(mk(0, 1, 0, n - i - 1));
    end
    q.push_back(mk(0, 0, 1, 0));
  endtask

  // Check the current cycle, then drive inputs for the next rising edge.
  task automatic step(input bit st, input bit ab, input bit rs,
                      input int w, input int g, input int c);
    exp_t e;
    @(negedge clk);
    e = (q.size() > 0) ? q.pop_front() : mk(0, 0, 0, 0);
    if (chk_en) begin
      check("pulse_out",   32'(pulse_out),   32'(e.p));
      check("busy",        32'(busy),        32'(e.b));
      check("done",        32'(done),        32'(e.d));
      check("pulses_left", 32'(pulses_left), 32'(e.l));
    end
    if (done === 1'b1) done_seen++;
    if (busy === 1'b1) busy_cnt++;
    start = st; abort = ab; reset = rs;
    width = CW'(w); gap = CW'(g); count = CW'(c);
    if (rs)
      q.delete();
    else if (e.b) begin
      if (ab) q.delete();
    end else if (st && !ab) begin
      if (c == 0) q.push_back(mk(0, 0, 1, 0));
      else push_train(w, g, c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic go(input int w, input int g, input int c);
    step(1, 0, 0, w, g, c);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    width = '0; gap = '0; count = '0;

    // Reset for two cycles; outputs are only defined after the first edge.
    step(0, 0, 1, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 1, 0, 0, 0);
    idle(2);

    // Basic train: 1,1,0,0,0 x2 then 1,1, then done.
    go(2, 3, 3);
    idle(15);

    // Zero width/gap, then an empty train.
    go(0, 0, 2);
    idle(5);
    go(0, 0, 0);
    idle(3);

    // Changes and a second start during a train are ignored.
    done_seen = 0;
    go(3, 2, 3);
    idle(2);
    step(1, 0, 0, 7, 9, 5);
    idle(1);
    step(1, 0, 0, 1, 1, 1);
    idle(15);
    check("single_done", 32'(done_seen), 32'd1);

    // Abort in the second high phase, no done afterwards.
    done_seen = 0;
    go(4, 2, 5);
    idle(7);
    step(0, 1, 0, 0, 0, 0);
    idle(4);
    check("abort_no_done", 32'(done_seen), 32'd0);
    // start and abort together in IDLE: nothing happens.
    step(1, 1, 0, 3, 3, 3);
    idle(4);

    // Reset in the middle of a low phase.
    go(2, 4, 3);
    idle(3);
    step(0, 0, 1, 0, 0, 0);
    idle(2);

    // Back-to-back: start on the done cycle.
    go(1, 1, 1);
    idle(1);
    go(1, 1, 1);
    idle(3);

    // Maximum field values.
    go(0, 0, 0);
    idle(1);
    busy_cnt = 0;
    done_seen = 0;
    go(15, 15, 15);
    idle(460);
    check("max_busy_total", 32'(busy_cnt), 32'd435);
    check("max_done", 32'(done_seen), 32'd1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 199) == 0),
           int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
           int'($urandom_range(0, 4)));
    end
    idle(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
